// File: rtl/writeback_stage.sv
// writeback_stage: registers memory-stage results and commits them to the register file one cycle later
module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              mem_wb,
    input  logic [ADDR_W-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              commit_valid,
    output logic [ADDR_W-1:0] commit_dst,
    output logic [DATA_W-1:0] commit_data,
    output logic [CNT_W-1:0]  wb_count
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    // x0 reads zero; the pending commit is forwarded so no stale window exists
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        return (a == '0) ? '0 : (valid_q && a == dst_q) ? data_q : regs_q[a];
    endfunction

    // commit the held result and capture the next one; everything holds on stall
    always_comb begin
        valid_d = valid_q;
        dst_d   = dst_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        if (enable) begin
            if (valid_q) begin
                regs_d[dst_q] = data_q;
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            end
            valid_d = mem_wb && (mem_dst != '0);
            dst_d   = mem_dst;
            data_d  = mem_data;
        end
    end

    // state registers; reset drops any pending commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dst_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            regs_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
        end
    end

    assign rs1_data     = read_port(rs1_addr);
    assign rs2_data     = read_port(rs2_addr);
    assign commit_valid = valid_q;
    assign commit_dst   = dst_q;
    assign commit_data  = data_q;
    assign wb_count     = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: scoreboard bench for writeback_stage with a small register-file model
module tb_writeback_stage;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        mem_wb = 1'b0;
    logic [4:0]  mem_dst = '0;
    logic [31:0] mem_data = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [31:0] rs1_data, rs2_data, commit_data;
    logic        commit_valid;
    logic [4:0]  commit_dst;
    logic [CW-1:0] wb_count;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [4:0]  m_dst;
    logic [31:0] m_data;
    int          m_cnt;
    logic [36:0] sb_q [$];

    writeback_stage #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .mem_wb(mem_wb), .mem_dst(mem_dst), .mem_data(mem_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .commit_valid(commit_valid), .commit_dst(commit_dst),
        .commit_data(commit_data), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (m_valid && a == m_dst) return m_data;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_valid = 1'b0;
        m_dst = '0;
        m_data = '0;
        m_cnt = 0;
        sb_q.delete();
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        rs1_addr = a1;
        rs2_addr = a2;
        #1;
        check("rs1", 64'(rs1_data), 64'(m_read(a1)));
        check("rs2", 64'(rs2_data), 64'(m_read(a2)));
    endtask

    task automatic step(input logic en, input logic wb, input logic [4:0] d, input logic [31:0] v);
        logic [36:0] e;
        @(negedge clk);
        enable = en;
        mem_wb = wb;
        mem_dst = d;
        mem_data = v;
        if (en && wb && d != 0) sb_q.push_back({d, v});
        @(posedge clk);
        #1;
        if (en) begin
            if (m_valid) begin
                m_regs[m_dst] = m_data;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
            m_valid = wb && d != 0;
            m_dst = d;
            m_data = v;
        end
        check("commit_valid", 64'(commit_valid), 64'(m_valid));
        if (en && m_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 64'(1), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check("commit_dst", 64'(commit_dst), 64'(e[36:32]));
                check("commit_data", 64'(commit_data), 64'(e[31:0]));
            end
        end
        check("wb_count", 64'(wb_count), 64'(m_cnt));
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_valid", 64'(commit_valid), 64'(0));
        check("rst_dst", 64'(commit_dst), 64'(0));
        check("rst_data", 64'(commit_data), 64'(0));
        check("rst_count", 64'(wb_count), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 1, 5, 32'hDEADBEEF);
        rd(5, 0);
        check("t1_bypass", 64'(rs1_data), 64'h0000_0000_DEAD_BEEF);
        step(1, 0, 0, 32'h0);
        rd(5, 5);
        check("t1_regfile", 64'(rs1_data), 64'h0000_0000_DEAD_BEEF);
        check("t1_count", 64'(wb_count), 64'(1));

        step(1, 1, 0, 32'h12345678);
        rd(0, 0);
        check("t2_x0", 64'(rs1_data | rs2_data), 64'(0));
        check("t2_count", 64'(wb_count), 64'(1));

        step(1, 1, 7, 32'h11);
        rd(5, 7);
        check("t3_first", 64'(rs2_data), 64'h11);
        step(1, 1, 7, 32'h22);
        rd(5, 7);
        check("t3_second", 64'(rs2_data), 64'h22);
        step(1, 0, 7, 32'h33);
        rd(7, 7);
        check("t3_third", 64'(rs2_data), 64'h22);
        step(1, 0, 0, 32'h0);
        check("t3_count", 64'(wb_count), 64'(3));

        step(1, 1, 3, 32'hA5A5A5A5);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 5'(i + 10), 32'hBAD0_0000 + 32'(i));
            rd(3, 5'(i + 10));
            check("t4_bypass", 64'(rs1_data), 64'h0000_0000_A5A5_A5A5);
            check("t4_count", 64'(wb_count), 64'(3));
        end
        step(1, 0, 0, 32'h0);
        check("t4_commit", 64'(wb_count), 64'(4));
        rd(3, 10);

        step(1, 1, 9, 32'hCAFE0000);
        rs1_addr = 9;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t5_valid", 64'(commit_valid), 64'(0));
        check("t5_dst", 64'(commit_dst), 64'(0));
        check("t5_data", 64'(commit_data), 64'(0));
        check("t5_count", 64'(wb_count), 64'(0));
        check("t5_rs1", 64'(rs1_data), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b0;
        rd(9, 3);
        step(1, 0, 0, 32'h0);
        rd(9, 5);
        check("t5_after", 64'(rs1_data), 64'(0));

        for (int i = 0; i < 20; i++) begin
            step(1, 1, 5'(12 + i % 5), 32'h1000 + 32'(i));
            rd(5'(12 + i % 5), 5'(12 + (i + 1) % 5));
        end
        step(1, 0, 0, 32'h0);
        check("t6_sat", 64'(wb_count), 64'hF);
        rd(16, 15);
        check("t6_last", 64'(rs1_data), 64'h1013);
        step(1, 1, 20, 32'h77);
        check("t6_hold", 64'(wb_count), 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
